piso_scan_ctrl: RTL and testbench

Sequencer for a daisy-chain of 8-bit parallel-in/serial-out shift registers (HC165-style, active-low shift/load, clock inhibit). On request it generates the load pulse and a divided shift clock for the chain, samples the serial output, and presents the whole chain contents as one parallel word with a completion strobe. It sits between the external PISO chain (buttons, DIP switches, input expanders) and the register/CPU side of the design.

---
 rtl/piso_scan_ctrl_pkg.sv | 39 +++
 rtl/piso_scan_ctrl_if.sv | 35 +++
 rtl/piso_scan_ctrl_tick.sv | 45 ++++
 rtl/piso_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_piso_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : piso_scan_pkg
// Desc    : Shared types and helpers for the PISO chain scan controller:
//           FSM state encoding, counter width helpers, divider legality check.
// Rev     : 1.0  initial release
// ============================================================================
package piso_scan_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Chain word width for a given number of 8-bit chips.
  function automatic int chain_width(input int num_chips);
    return 8 * num_chips;
  endfunction

  // Bit counter must be able to hold the value W itself.
  function automatic int bit_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Phase timer width; never narrower than one bit.
  function automatic int tick_w(input int half);
    return (half <= 1) ? 1 : $clog2(half);
  endfunction

  // The shift clock needs an even divider of at least 2 for a 50% duty cycle.
  function automatic bit clk_div_ok(input int div);
    return (div >= 2) && ((div % 2) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : piso_scan_ctrl_if
// Desc    : Bundle of the scan request, PISO chain pins and parallel result.
//           slave  = the scan controller
//           master = its environment (register side and the chain itself)
// Rev     : 1.0  initial release
// ============================================================================
interface piso_scan_ctrl_if #(
  parameter int NUM_CHIPS = 2
);
  localparam int W = 8 * NUM_CHIPS;

  logic         start;
  logic         serial_in;
  logic         sclk;
  logic         shld_n;
  logic         clk_inh;
  logic         busy;
  logic         data_valid;
  logic [W-1:0] data_out;
  logic         changed;

  modport slave (
    input  start, serial_in,
    output sclk, shld_n, clk_inh, busy, data_valid, data_out, changed
  );

  modport master (
    output start, serial_in,
    input  sclk, shld_n, clk_inh, busy, data_valid, data_out, changed
  );

endinterface
`default_nettype wire

// File: rtl/piso_scan_ctrl_tick.sv
`default_nettype none
// ============================================================================
// Module  : piso_scan_tick
// Desc    : Half-period phase timer. tc is high on the last cycle of each
//           HALF-cycle phase; restart forces the next cycle to be the first
//           cycle of a fresh phase.
// Rev     : 1.0  initial release
// ============================================================================
module piso_scan_tick
  import piso_scan_pkg::*;
#(
  parameter int HALF = 2
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  restart,
  output logic tc
);

  localparam int CW = tick_w(HALF);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(HALF - 1));

  // Next phase count: wrap at terminal count or on a state change.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tc) begin
      cnt_d = '0;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : piso_scan_ctrl
// Desc    : Sequencer for a daisy chain of HC165-style 8-bit PISO registers.
//           Generates load pulse and divided shift clock, captures the serial
//           stream (first bit -> MSB) and presents it with a one-cycle strobe.
//           All outputs are registered decodes of the current state, so pins
//           trail the FSM by one clk cycle.
//           Optional macro PISO_SCAN_CHANGE_EN: builds the change detector
//           driving `changed`; otherwise `changed` is tied low.
// Rev     : 1.0  initial release
// ============================================================================
module piso_scan_ctrl
  import piso_scan_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int CLK_DIV   = 4
) (
  input wire               clk,
  input wire               rst,
  piso_scan_ctrl_if.slave  bus
);

  localparam int W    = chain_width(NUM_CHIPS);
  localparam int HALF = CLK_DIV / 2;
  localparam int BCW  = bit_cnt_w(W);

  if (!clk_div_ok(CLK_DIV)) begin : g_div_check
    $error("piso_scan_ctrl: CLK_DIV must be even and >= 2");
  end

  state_e         state_q, state_d;
  logic           load_hi_q, load_hi_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]   cap_q, cap_d;

  logic           sclk_q, sclk_d;
  logic           shld_n_q, shld_n_d;
  logic           clk_inh_q, clk_inh_d;
  logic           busy_q, busy_d;
  logic           data_valid_q, data_valid_d;
  logic [W-1:0]   data_out_q, data_out_d;

  logic           tc;
  logic           state_chg;
  logic [BCW-1:0] bit_cnt_inc;

  assign state_chg   = (state_d != state_q);
  assign bit_cnt_inc = bit_cnt_q + BCW'(1);

  piso_scan_tick #(
    .HALF (HALF)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (state_chg),
    .tc      (tc)
  );

  // FSM next state, load phase, bit count and capture shift register.
  always_comb begin
    state_d   = state_q;
    load_hi_d = load_hi_q;
    bit_cnt_d = bit_cnt_q;
    cap_d     = cap_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = LOAD;
          load_hi_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      LOAD: begin
        if (tc) begin
          if (!load_hi_q) begin
            load_hi_d = 1'b1;
          end else begin
            load_hi_d = 1'b0;
            state_d   = SHIFT_LO;
          end
        end
      end
      SHIFT_LO: begin
        // Sample on the last low cycle: the chain has settled since the
        // previous rising edge and the next edge has not happened yet.
        if (tc) begin
          cap_d     = {cap_q[W-2:0], bus.serial_in};
          bit_cnt_d = bit_cnt_inc;
          state_d   = (bit_cnt_inc == BCW'(W)) ? DONE : SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tc) begin
          state_d = SHIFT_LO;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode of the current state, registered below.
  always_comb begin
    sclk_d       = ((state_q == LOAD) && load_hi_q) || (state_q == SHIFT_HI);
    shld_n_d     = (state_q != LOAD);
    clk_inh_d    = (state_q == IDLE) || (state_q == DONE);
    busy_d       = (state_q == LOAD) || (state_q == SHIFT_LO) ||
                   (state_q == SHIFT_HI);
    data_valid_d = (state_q == DONE);
    data_out_d   = (state_q == DONE) ? cap_q : data_out_q;
  end

`ifdef PISO_SCAN_CHANGE_EN
  logic changed_q;
  logic changed_d;

  // Change flag: compare the fresh capture against the word it replaces.
  always_comb begin
    changed_d = (state_q == DONE) && (cap_q != data_out_q);
  end

  assign bus.changed = changed_q;
`else
  assign bus.changed = 1'b0;
`endif

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      load_hi_q    <= 1'b0;
      bit_cnt_q    <= '0;
      cap_q        <= '0;
      sclk_q       <= 1'b0;
      shld_n_q     <= 1'b1;
      clk_inh_q    <= 1'b1;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
`ifdef PISO_SCAN_CHANGE_EN
      changed_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      load_hi_q    <= load_hi_d;
      bit_cnt_q    <= bit_cnt_d;
      cap_q        <= cap_d;
      sclk_q       <= sclk_d;
      shld_n_q     <= shld_n_d;
      clk_inh_q    <= clk_inh_d;
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
`ifdef PISO_SCAN_CHANGE_EN
      changed_q    <= changed_d;
`endif
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.shld_n     = shld_n_q;
  assign bus.clk_inh    = clk_inh_q;
  assign bus.busy       = busy_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data_out   = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_piso_scan_ctrl
// Desc    : Self-checking bench for piso_scan_ctrl. Behavioural HC165 chain
//           models feed two DUT instances (2 chips / div 4 and 1 chip / div 2);
//           expected words are queued at each start and checked by monitors.
// Rev     : 1.0  initial release
// ============================================================================
module tb_piso_scan_ctrl;

  typedef struct {
    logic [15:0] data;
    int          acc;
    logic        chg;
  } exp_t;

  localparam int LAT_A = 67;
  localparam int LAT_B = 18;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_scan_ctrl_if #(.NUM_CHIPS(2)) bus  ();
  piso_scan_ctrl_if #(.NUM_CHIPS(1)) bus2 ();

  piso_scan_ctrl #(.NUM_CHIPS(2), .CLK_DIV(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  piso_scan_ctrl #(.NUM_CHIPS(1), .CLK_DIV(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Chain models: rising sclk loads when shld_n=0, otherwise shifts toward
  // the last chip, whose QH is serial_in.
  logic [15:0] par_a = '0;
  logic [15:0] chain_a = '0;
  logic [7:0]  par_b = '0;
  logic [7:0]  chain_b = '0;

  always @(posedge bus.sclk)
    if (!bus.clk_inh) chain_a <= bus.shld_n ? {chain_a[14:0], 1'b0} : par_a;
  always @(posedge bus2.sclk)
    if (!bus2.clk_inh) chain_b <= bus2.shld_n ? {chain_b[6:0], 1'b0} : par_b;

  assign bus.serial_in  = chain_a[15];
  assign bus2.serial_in = chain_b[7];

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [15:0] prev_a = '0;
  logic [15:0] prev_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic chg_model(input logic [15:0] d, input logic [15:0] prev);
`ifdef PISO_SCAN_CHANGE_EN
    return d != prev;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_a(input logic [15:0] d, input int acc);
    exp_t e;
    e.data = d;
    e.acc  = acc;
    e.chg  = chg_model(d, prev_a);
    prev_a = d;
    sb_a.push_back(e);
  endtask

  task automatic pulse_a(input logic [15:0] d);
    @(negedge clk);
    par_a     = d;
    bus.start = 1'b1;
    push_a(d, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb_a.size() + sb_b.size()), 32'd0);
    sb_a.delete();
    sb_b.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_sclk"},       32'(bus.sclk),       32'd0);
    chk({tag, "_shld_n"},     32'(bus.shld_n),     32'd1);
    chk({tag, "_clk_inh"},    32'(bus.clk_inh),    32'd1);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
    chk({tag, "_data_out"},   32'(bus.data_out),   32'd0);
    chk({tag, "_changed"},    32'(bus.changed),    32'd0);
  endtask

  // Monitor and protocol checker for the 2-chip instance.
  logic prev_sclk = 1'b0;
  logic prev_shld = 1'b1;
  logic prev_busy = 1'b0;
  int   load_edges = 0;
  int   shift_edges = 0;

  always @(negedge clk) begin
    if (rst) begin
      load_edges  = 0;
      shift_edges = 0;
    end else begin
      if (bus.sclk && !prev_sclk) begin
        chk("sclk_rise_inhibited", 32'(bus.clk_inh), 32'd0);
        if (!bus.shld_n) load_edges++;
        else             shift_edges++;
      end
      if (bus.sclk && (bus.shld_n != prev_shld))
        chk("shld_n_toggle_sclk_hi", 32'(bus.shld_n), 32'(prev_shld));
      if (bus.busy && bus.data_valid)
        chk("busy_and_valid", 32'(bus.busy && bus.data_valid), 32'd0);
      if (prev_busy && !bus.busy)
        chk("busy_drop_without_valid", 32'(bus.data_valid), 32'd1);
      if (bus.data_valid) begin
        if (sb_a.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_a.pop_front();
          chk("data_out",    32'(bus.data_out), 32'(e.data));
          chk("latency",     32'(cyc - e.acc),  32'(LAT_A));
          chk("changed",     32'(bus.changed),  32'(e.chg));
          chk("load_edges",  32'(load_edges),   32'd1);
          chk("shift_edges", 32'(shift_edges),  32'd15);
        end
        load_edges  = 0;
        shift_edges = 0;
      end
    end
    prev_sclk = bus.sclk;
    prev_shld = bus.shld_n;
    prev_busy = bus.busy;
  end

  // Monitor for the 1-chip, divide-by-2 instance.
  always @(negedge clk) begin
    if (!rst && bus2.data_valid) begin
      if (sb_b.size() == 0) begin
        chk("b_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_b.pop_front();
        chk("b_data_out", 32'(bus2.data_out), 32'(e.data));
        chk("b_latency",  32'(cyc - e.acc),   32'(LAT_B));
        chk("b_changed",  32'(bus2.changed),  32'(e.chg));
      end
    end
  end

  initial begin
    int a;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_values("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single scan, chips 0x3C (first) and 0xA5 (last).
    pulse_a(16'hA53C);
    drain(200);

    // start held every cycle during a scan: one scan only.
    @(negedge clk);
    par_a     = 16'h1234;
    bus.start = 1'b1;
    push_a(16'h1234, cyc + 1);
    repeat (60) @(negedge clk);
    bus.start = 1'b0;
    drain(200);

    // start held across DONE: next scan accepted after one IDLE cycle.
    @(negedge clk);
    par_a     = 16'h0F0F;
    bus.start = 1'b1;
    a         = cyc + 1;
    push_a(16'h0F0F, a);
    push_a(16'h0F0F, a + LAT_A + 1);
    repeat (100) @(negedge clk);
    bus.start = 1'b0;
    drain(300);

    // Reset just after bit 7 is sampled; scan aborts, data_out clears.
    @(negedge clk);
    par_a     = 16'h5555;
    bus.start = 1'b1;
    push_a(16'h5555, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (31) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    reset_values("midscan_rst");
    sb_a.delete();
    prev_a = '0;
    prev_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_a(16'hFFFF);
    drain(200);

    // Change flag from a clean reset: 0x0000 then 0x0100.
    @(negedge clk);
    rst = 1'b1;
    prev_a = '0;
    prev_b = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_a(16'h0000);
    drain(200);
    pulse_a(16'h0100);
    drain(200);

    // Divide-by-2, single chip, 0x81.
    begin
      exp_t e;
      @(negedge clk);
      par_b      = 8'h81;
      bus2.start = 1'b1;
      e.data     = 16'h0081;
      e.acc      = cyc + 1;
      e.chg      = chg_model(16'h0081, prev_b);
      prev_b     = 16'h0081;
      sb_b.push_back(e);
      @(negedge clk);
      bus2.start = 1'b0;
    end
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
